// File: rtl/cnn_conv1d_scheduler_if.sv
// Bundle of layer-config, weight-load, activation-window, pipeline and output-buffer
// signals between the conv1d scheduler (master) and its surroundings (slave).
interface cnn_conv1d_scheduler_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int PARALLEL_MAC_UNITS = 4,
    parameter int ADDR_WIDTH         = 12,
    parameter int CNT_WIDTH          = 12,
    parameter int IDX_WIDTH          = (PARALLEL_MAC_UNITS > 1) ? $clog2(PARALLEL_MAC_UNITS) : 1
);
    // Handshakes: a transfer happens on a clk edge where valid and ready are both high;
    // valid never waits on ready, and the payload holds steady while valid is high and ready low.
    logic                                           start;
    logic [CNT_WIDTH-1:0]                           num_outputs;
    logic [CNT_WIDTH-1:0]                           stride;
    logic [ADDR_WIDTH-1:0]                          in_base;
    logic [ADDR_WIDTH-1:0]                          out_base;

    logic                                           wgt_wr_en;
    logic [IDX_WIDTH-1:0]                           wgt_wr_idx;
    logic signed [DATA_WIDTH-1:0]                   wgt_wr_data;

    logic                                           busy;
    logic                                           done;

    logic [ADDR_WIDTH-1:0]                          win_addr;
    logic [PARALLEL_MAC_UNITS-1:0][DATA_WIDTH-1:0]  win_data;

    logic                                           pipe_valid_in;
    logic                                           pipe_ready_out;
    logic [PARALLEL_MAC_UNITS-1:0][DATA_WIDTH-1:0]  pipe_data_in;
    logic [PARALLEL_MAC_UNITS-1:0][DATA_WIDTH-1:0]  pipe_weights_in;
    logic                                           pipe_valid_out;
    logic                                           pipe_ready_in;
    logic signed [DATA_WIDTH-1:0]                   pipe_data_out;

    logic                                           out_wr_en;
    logic                                           out_wr_ready;
    logic [ADDR_WIDTH-1:0]                          out_wr_addr;
    logic [DATA_WIDTH-1:0]                          out_wr_data;

    logic [1:0]                                     dbg_state;

    modport master (
        input  start, num_outputs, stride, in_base, out_base,
        input  wgt_wr_en, wgt_wr_idx, wgt_wr_data,
        output busy, done,
        output win_addr,
        input  win_data,
        output pipe_valid_in, pipe_data_in, pipe_weights_in,
        input  pipe_ready_out,
        input  pipe_valid_out, pipe_data_out,
        output pipe_ready_in,
        output out_wr_en, out_wr_addr, out_wr_data,
        input  out_wr_ready,
        output dbg_state
    );

    modport slave (
        output start, num_outputs, stride, in_base, out_base,
        output wgt_wr_en, wgt_wr_idx, wgt_wr_data,
        input  busy, done,
        input  win_addr,
        output win_data,
        input  pipe_valid_in, pipe_data_in, pipe_weights_in,
        output pipe_ready_out,
        output pipe_valid_out, pipe_data_out,
        input  pipe_ready_in,
        input  out_wr_en, out_wr_addr, out_wr_data,
        output out_wr_ready,
        input  dbg_state
    );
endinterface

// File: rtl/cnn_conv1d_scheduler.sv
// Drives one CNN MAC pipeline through a 1-D convolution pass: issues activation windows
// with the local tap bank, and retires ReLU'd results to sequential output addresses.
module cnn_conv1d_scheduler #(
    parameter int DATA_WIDTH         = 8,
    parameter int PARALLEL_MAC_UNITS = 4,
    parameter int ADDR_WIDTH         = 12,
    parameter int CNT_WIDTH          = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    cnn_conv1d_scheduler_if.master sched_if
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                                         state_q, state_d;
    logic [CNT_WIDTH-1:0]                           num_q, num_d;
    logic [CNT_WIDTH-1:0]                           stride_q, stride_d;
    logic [CNT_WIDTH-1:0]                           issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]                           retire_cnt_q, retire_cnt_d;
    logic [ADDR_WIDTH-1:0]                          out_base_q, out_base_d;
    logic [ADDR_WIDTH-1:0]                          win_addr_q, win_addr_d;
    logic [PARALLEL_MAC_UNITS-1:0][DATA_WIDTH-1:0]  wgt_q, wgt_d;

    logic issuing;
    logic retiring;
    logic issue_fire;
    logic retire_fire;
    logic last_issue;
    logic last_retire;

    assign issuing     = (state_q == RUN) && (issue_cnt_q < num_q);
    assign retiring    = (state_q == RUN) || (state_q == DRAIN);
    assign issue_fire  = issuing && sched_if.pipe_ready_out;
    assign retire_fire = retiring && sched_if.pipe_valid_out && sched_if.out_wr_ready;
    assign last_issue  = (issue_cnt_q + CNT_WIDTH'(1)) == num_q;
    assign last_retire = (retire_cnt_q + CNT_WIDTH'(1)) == num_q;

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        stride_d     = stride_q;
        out_base_d   = out_base_q;
        issue_cnt_d  = issue_cnt_q;
        retire_cnt_d = retire_cnt_q;
        win_addr_d   = win_addr_q;
        wgt_d        = wgt_q;

        if (retire_fire) begin
            retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (sched_if.wgt_wr_en) begin
                    wgt_d[sched_if.wgt_wr_idx] = sched_if.wgt_wr_data;
                end
                if (sched_if.start) begin
                    num_d        = sched_if.num_outputs;
                    stride_d     = sched_if.stride;
                    out_base_d   = sched_if.out_base;
                    win_addr_d   = sched_if.in_base;
                    issue_cnt_d  = '0;
                    retire_cnt_d = '0;
                    state_d      = (sched_if.num_outputs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Window address is an accumulator: in_base + issue_cnt*stride, wrapping.
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
                    win_addr_d  = win_addr_q + ADDR_WIDTH'(stride_q);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((retire_fire && last_retire) || (retire_cnt_q == num_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            num_q        <= '0;
            stride_q     <= '0;
            out_base_q   <= '0;
            issue_cnt_q  <= '0;
            retire_cnt_q <= '0;
            win_addr_q   <= '0;
            wgt_q        <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            stride_q     <= stride_d;
            out_base_q   <= out_base_d;
            issue_cnt_q  <= issue_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            win_addr_q   <= win_addr_d;
            wgt_q        <= wgt_d;
        end
    end

    assign sched_if.busy            = retiring;
    assign sched_if.done            = (state_q == DONE);
    assign sched_if.win_addr        = win_addr_q;
    assign sched_if.pipe_valid_in   = issuing;
    assign sched_if.pipe_data_in    = sched_if.win_data;
    assign sched_if.pipe_weights_in = wgt_q;
    assign sched_if.pipe_ready_in   = retiring && sched_if.out_wr_ready;
    assign sched_if.out_wr_en       = retire_fire;
    assign sched_if.out_wr_addr     = out_base_q + ADDR_WIDTH'(retire_cnt_q);
    assign sched_if.out_wr_data     = sched_if.pipe_data_out;
    assign sched_if.dbg_state       = state_q;

    win_addr_hold_a : assert property (@(posedge clk) disable iff (rst)
        (sched_if.pipe_valid_in && !sched_if.pipe_ready_out) |=> $stable(sched_if.win_addr));

endmodule

// File: tb/tb_cnn_conv1d_scheduler.sv
// Bench for cnn_conv1d_scheduler: a 4-stage stall-all pipeline stand-in, an activation
// memory, and a scoreboard of expected output writes built from the layer arithmetic.
module tb_cnn_conv1d_scheduler;
    localparam int DW = 8;
    localparam int P  = 4;
    localparam int AW = 12;
    localparam int CW = 12;
    localparam int IW = $clog2(P);
    localparam int AMOD = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cnn_conv1d_scheduler_if #(
        .DATA_WIDTH(DW), .PARALLEL_MAC_UNITS(P), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) sif ();

    cnn_conv1d_scheduler #(
        .DATA_WIDTH(DW), .PARALLEL_MAC_UNITS(P), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0]    exp_q[$];
    logic signed [DW-1:0] act_mem [AMOD];
    int model_w [P];

    int in_base_m, stride_m, iss;
    int wr_cnt, wr_first, wr_last, done_cnt, busy_cnt, vin_cnt, cyc;
    bit first_wr, prev_stall, saw_zero;
    logic [AW-1:0] prev_addr;
    int rdy_mode;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_relu(input int s);
        if (s > 127) return 127;
        if (s < 0) return 0;
        return s;
    endfunction

    // Expected result for the window starting at activation address a.
    function automatic int ref_result(input int a);
        int sum = 0;
        for (int k = 0; k < P; k++) begin
            sum += int'(act_mem[(a + k) % AMOD]) * model_w[k];
        end
        return sat_relu(sum);
    endfunction

    function automatic logic [DW-1:0] stub_mac(input logic [P-1:0][DW-1:0] d,
                                               input logic [P-1:0][DW-1:0] w);
        int s = 0;
        for (int k = 0; k < P; k++) begin
            s += int'($signed(d[k])) * int'($signed(w[k]));
        end
        return DW'(sat_relu(s));
    endfunction

    // Activation buffer: combinational read of P elements at win_addr.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            sif.win_data[k] = act_mem[sif.win_addr + AW'(k)];
        end
    end

    // Pipeline stand-in: 4 register stages, whole pipe stalls when its output is held.
    logic [3:0]          st_v;
    logic [3:0][DW-1:0]  st_d;
    logic                pipe_adv;

    assign pipe_adv           = !st_v[3] || sif.pipe_ready_in;
    assign sif.pipe_ready_out = pipe_adv;
    assign sif.pipe_valid_out = st_v[3];
    assign sif.pipe_data_out  = st_d[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            st_v <= '0;
            st_d <= '0;
        end else if (pipe_adv) begin
            st_v <= {st_v[2:0], sif.pipe_valid_in};
            st_d <= {st_d[2:0], stub_mac(sif.pipe_data_in, sif.pipe_weights_in)};
        end
    end

    // Output-buffer ready pattern generator.
    initial begin
        int pat = 0;
        sif.out_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       sif.out_wr_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
                2:       sif.out_wr_ready = 1'($urandom_range(0, 1));
                default: sif.out_wr_ready = 1'b1;
            endcase
            pat++;
        end
    end

    // Monitor: scoreboard writes, window addresses and hold-under-stall.
    initial begin
        logic [AW+DW-1:0] e;
        int exp_win;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (sif.out_wr_en) begin
                    wr_cnt++;
                    if (!first_wr) begin
                        wr_first = cyc;
                        first_wr = 1'b1;
                    end
                    wr_last = cyc;
                    check_eq("wr_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("wr_addr", sif.out_wr_addr, e[AW+DW-1:DW]);
                        check_eq("wr_data", sif.out_wr_data, e[DW-1:0]);
                    end
                end
                if (prev_stall && sif.pipe_valid_in) begin
                    check_eq("win_hold", sif.win_addr, prev_addr);
                end
                if (sif.pipe_valid_in && sif.pipe_ready_out) begin
                    exp_win = (in_base_m + iss * stride_m) % AMOD;
                    check_eq("win_addr", sif.win_addr, exp_win);
                    if (sif.win_addr == '0) saw_zero = 1'b1;
                    iss++;
                end
                prev_stall = sif.pipe_valid_in && !sif.pipe_ready_out;
                prev_addr  = sif.win_addr;
                if (sif.done) done_cnt++;
                if (sif.busy) busy_cnt++;
                if (sif.pipe_valid_in) vin_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_wgt(input int idx, input int val, input bit taken);
        sif.wgt_wr_en   = 1'b1;
        sif.wgt_wr_idx  = IW'(idx);
        sif.wgt_wr_data = DW'(val);
        tick();
        sif.wgt_wr_en = 1'b0;
        if (taken) model_w[idx] = val;
    endtask

    task automatic start_pass(input int num, input int stride, input int in_base, input int out_base);
        in_base_m = in_base;
        stride_m  = stride;
        iss       = 0;
        wr_cnt    = 0;
        first_wr  = 1'b0;
        done_cnt  = 0;
        busy_cnt  = 0;
        vin_cnt   = 0;
        exp_q.delete();
        for (int i = 0; i < num; i++) begin
            exp_q.push_back({AW'((out_base + i) % AMOD),
                             DW'(ref_result((in_base + i * stride) % AMOD))});
        end
        sif.num_outputs = CW'(num);
        sif.stride      = CW'(stride);
        sif.in_base     = AW'(in_base);
        sif.out_base    = AW'(out_base);
        sif.start       = 1'b1;
        tick();
        sif.start = 1'b0;
        if (num > 0) begin
            check_eq("first_issue", sif.pipe_valid_in, 1);
            check_eq("busy_on", sif.busy, 1);
        end else begin
            check_eq("zero_done", sif.done, 1);
            check_eq("zero_busy", sif.busy, 0);
        end
    endtask

    task automatic wait_done(input int num, input bit gap_chk);
        int n = 0;
        while (!sif.done && n < 2000) begin
            tick();
            n++;
        end
        check_eq("done_seen", sif.done, 1);
        repeat (3) tick();
        check_eq("done_pulses", done_cnt, 1);
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("wr_count", wr_cnt, num);
        check_eq("busy_after", sif.busy, 0);
        if (gap_chk && num > 0) check_eq("no_gaps", wr_last - wr_first, num - 1);
        exp_q.delete();
    endtask

    initial begin
        int nv, n;
        logic [DW-1:0] wexp;
        rst             = 1'b1;
        sif.start       = 1'b0;
        sif.num_outputs = '0;
        sif.stride      = '0;
        sif.in_base     = '0;
        sif.out_base    = '0;
        sif.wgt_wr_en   = 1'b0;
        sif.wgt_wr_idx  = '0;
        sif.wgt_wr_data = '0;
        rdy_mode        = 0;
        for (int a = 0; a < AMOD; a++) act_mem[a] = DW'(a & 63);
        for (int k = 0; k < P; k++) model_w[k] = 0;
        repeat (3) tick();

        check_eq("rst_busy", sif.busy, 0);
        check_eq("rst_done", sif.done, 0);
        check_eq("rst_valid_in", sif.pipe_valid_in, 0);
        check_eq("rst_ready_in", sif.pipe_ready_in, 0);
        check_eq("rst_wr_en", sif.out_wr_en, 0);
        check_eq("rst_win_addr", sif.win_addr, 0);
        check_eq("rst_weights", 32'(sif.pipe_weights_in), 0);
        rst = 1'b0;
        tick();

        // Ramp data, unit taps: 6,10,...,34 at 0x100..0x107, back to back.
        for (int k = 0; k < P; k++) write_wgt(k, 1, 1'b1);
        start_pass(8, 1, 0, 'h100);
        wait_done(8, 1'b1);

        // Negative taps clamp to zero.
        for (int k = 0; k < P; k++) write_wgt(k, -1, 1'b1);
        start_pass(8, 1, 0, 'h100);
        wait_done(8, 1'b1);

        // Saturation.
        for (int a = 0; a < AMOD; a++) act_mem[a] = 8'sd127;
        for (int k = 0; k < P; k++) write_wgt(k, 127, 1'b1);
        start_pass(8, 1, 0, 'h100);
        wait_done(8, 1'b1);

        // Output backpressure 1,0,0,1 with random data and taps.
        for (int a = 0; a < AMOD; a++) act_mem[a] = DW'(int'($urandom_range(0, 31)) - 16);
        for (int k = 0; k < P; k++) write_wgt(k, int'($urandom_range(0, 15)) - 8, 1'b1);
        rdy_mode = 1;
        start_pass(16, 2, int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)));
        wait_done(16, 1'b0);
        rdy_mode = 0;

        // Empty pass.
        start_pass(0, 1, 0, 'h200);
        wait_done(0, 1'b0);
        check_eq("zero_busy_cycles", busy_cnt, 0);
        check_eq("zero_valid_in", vin_cnt, 0);

        // Tap write during a pass is dropped.
        start_pass(12, 1, int'($urandom_range(0, AMOD - 1)), 'h400);
        nv = (model_w[0] == 5) ? 6 : 5;
        write_wgt(0, nv, 1'b0);
        wait_done(12, 1'b1);
        wexp = DW'(model_w[0]);
        check_eq("wgt_kept", sif.pipe_weights_in[0], wexp);

        // Random passes under random backpressure.
        rdy_mode = 2;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < P; k++) write_wgt(k, int'($urandom_range(0, 15)) - 8, 1'b1);
            n = int'($urandom_range(1, 24));
            start_pass(n, int'($urandom_range(0, 300)), int'($urandom_range(0, AMOD - 1)),
                       int'($urandom_range(0, AMOD - 1)));
            wait_done(n, 1'b0);
        end
        rdy_mode = 0;

        // Reset in the middle of a pass.
        start_pass(16, 1, 0, 'h200);
        n = 0;
        while (wr_cnt < 3 && n < 100) begin
            tick();
            n++;
        end
        check_eq("mid_writes", wr_cnt, 3);
        rst = 1'b1;
        exp_q.delete();
        tick();
        for (int k = 0; k < P; k++) model_w[k] = 0;
        check_eq("mid_rst_busy", sif.busy, 0);
        check_eq("mid_rst_valid_in", sif.pipe_valid_in, 0);
        check_eq("mid_rst_ready_in", sif.pipe_ready_in, 0);
        check_eq("mid_rst_wr_en", sif.out_wr_en, 0);
        check_eq("mid_rst_win_addr", sif.win_addr, 0);
        check_eq("mid_rst_weights", 32'(sif.pipe_weights_in), 0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) tick();
        check_eq("mid_rst_no_done", done_cnt, 0);

        // Window address wraps past the top of the activation buffer.
        for (int k = 0; k < P; k++) write_wgt(k, int'($urandom_range(0, 7)), 1'b1);
        saw_zero = 1'b0;
        start_pass(4, 1, 'hFFE, 'h300);
        wait_done(4, 1'b1);
        check_eq("wrap_zero", saw_zero, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
